// File: rtl/dmem_store_buffer_pkg.sv
// Shared memory-access types and lane helpers for the data-memory store buffer.
// Holds the CPU access-type and error enums, the buffered-store entry layout,
// and the byte-lane encode/extract functions used by the store and load paths.
package dmem_store_buffer_pkg;

    // CPU access type; the unsigned variants only differ on the load side.
    typedef enum logic [2:0] {
        DT_BYTE  = 3'd0,
        DT_HALF  = 3'd1,
        DT_WORD  = 3'd2,
        DT_UBYTE = 3'd4,
        DT_UHALF = 3'd5
    } mem_dt_e;

    // Access error reported back to the CPU.
    typedef enum logic [1:0] {
        ENOERR = 2'd0,
        EALIGN = 2'd1
    } errno_e;

    localparam int BE_W    = 4;
    localparam int SB_WA_W = 30;

    // One posted store: word address, byte enables and lane-positioned data.
    typedef struct packed {
        logic [SB_WA_W-1:0] wa;
        logic [BE_W-1:0]    be;
        logic [31:0]        data;
    } sb_entry_t;

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic dt_misaligned(input mem_dt_e dt, input logic [1:0] off);
        case (dt)
            DT_HALF, DT_UHALF: return off[0];
            DT_WORD:           return off != 2'b00;
            default:           return 1'b0;
        endcase
    endfunction

    // Byte enables for a store of the given type at byte offset off.
    function automatic logic [BE_W-1:0] dt_lane_be(input mem_dt_e dt, input logic [1:0] off);
        case (dt)
            DT_BYTE, DT_UBYTE: return 4'b0001 << off;
            DT_HALF, DT_UHALF: return 4'b0011 << off;
            default:           return 4'b1111;
        endcase
    endfunction

    // Right-aligned store data replicated across every lane it could occupy,
    // so the byte enables alone select the written bytes.
    function automatic logic [31:0] dt_lane_data(input mem_dt_e dt, input logic [31:0] wd);
        case (dt)
            DT_BYTE, DT_UBYTE: return {4{wd[7:0]}};
            DT_HALF, DT_UHALF: return {2{wd[15:0]}};
            default:           return wd;
        endcase
    endfunction

    // Pull the addressed byte/half out of a word and extend it to 32 bits.
    function automatic logic [31:0] dt_extract(input mem_dt_e dt, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (dt)
            DT_BYTE:  return {{24{b[7]}}, b};
            DT_UBYTE: return {24'h0, b};
            DT_HALF:  return {{16{h[15]}}, h};
            DT_UHALF: return {16'h0, h};
            default:  return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_store_buffer_fwd_merge.sv
// Store-to-load forwarding merge: overlays every valid buffered store that
// targets the load's word onto the raw RAM word, oldest first, so the newest
// store to each byte wins.
module sb_fwd_merge
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [31:0]        raw_i,
    input  logic [SB_WA_W-1:0] wa_i,
    input  sb_entry_t          ent_i [DEPTH],
    input  logic [DEPTH-1:0]   vld_i,
    input  logic [PTR_W-1:0]   head_i,
    output logic [31:0]        merged_o
);

    logic [PTR_W-1:0] idx;

    // Walk the ring from head (oldest) towards tail (newest), overwriting enabled bytes.
    always_comb begin
        merged_o = raw_i;
        idx      = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (vld_i[idx] && (ent_i[idx].wa == wa_i)) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (ent_i[idx].be[b]) begin
                        merged_o[8*b +: 8] = ent_i[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the CPU data port and the data RAM.
// Stores are queued in a DEPTH-entry ring and drained one per cycle whenever
// the RAM write port is free; loads read RAM combinationally and see pending
// stores through the forwarding merge, so a store is visible to the very next
// load even before it reaches RAM.
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WA_W  = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     d_addr,
    input  logic            d_we,
    input  logic [31:0]     d_wd,
    input  mem_dt_e         d_dt,
    output logic [31:0]     d_rd,
    output errno_e          d_err,
    output logic            d_stall,
    output logic [WA_W-1:0] m_raddr,
    input  logic [31:0]     m_rd,
    output logic [WA_W-1:0] m_waddr,
    output logic [31:0]     m_wd,
    output logic [BE_W-1:0] m_be,
    output logic            m_we,
    input  logic            m_busy,
    output logic            sb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Ring control state
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;

    // Entry storage; contents only matter while the matching valid bit is set
    sb_entry_t ent_q [DEPTH];

    logic      aligned;
    logic      full;
    logic      empty;
    logic      pop;
    logic      push;
    sb_entry_t new_ent;
    logic [31:0] merged;

    // Access checks and the entry a store would enqueue
    always_comb begin
        aligned      = ~dt_misaligned(d_dt, d_addr[1:0]);
        full         = (count_q == CNT_W'(DEPTH));
        empty        = (count_q == '0);
        new_ent.wa   = d_addr[31:2];
        new_ent.be   = dt_lane_be(d_dt, d_addr[1:0]);
        new_ent.data = dt_lane_data(d_dt, d_wd);
    end

    // Drain and accept decisions; a pop in the same cycle frees a slot for a full buffer
    always_comb begin
        pop     = ~empty & ~m_busy;
        push    = d_we & aligned & (~full | pop);
        d_stall = d_we & aligned & full & ~pop;
    end

    // Next ring state: pop retires head, push claims tail, both may happen together
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + 1'b1;
        end
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset discards every pending store immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Entry payload write at the tail slot
    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[tail_q] <= new_ent;
        end
    end

    // Forwarding merge over the live entries, including one being popped now
    sb_fwd_merge #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_merge (
        .raw_i    (m_rd),
        .wa_i     (d_addr[31:2]),
        .ent_i    (ent_q),
        .vld_i    (vld_q),
        .head_i   (head_q),
        .merged_o (merged)
    );

    // RAM write port shows the head entry; byte enables idle at zero when empty
    always_comb begin
        m_we     = pop;
        m_waddr  = ent_q[head_q].wa[WA_W-1:0];
        m_wd     = ent_q[head_q].data;
        m_be     = empty ? '0 : ent_q[head_q].be;
        sb_empty = empty;
    end

    // Load side: read address, extracted/extended data and the alignment error
    always_comb begin
        m_raddr = d_addr[WA_W+1:2];
        d_rd    = aligned ? dt_extract(d_dt, d_addr[1:0], merged) : 32'h0;
        d_err   = (~rst & ~aligned) ? EALIGN : ENOERR;
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the posted stores and a model copy of the RAM.
module tb_dmem_store_buffer;
    import dmem_store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wd;
    mem_dt_e     d_dt;
    logic [31:0] d_rd;
    errno_e      d_err;
    logic        d_stall;
    logic [29:0] m_raddr;
    logic [31:0] m_rd;
    logic [29:0] m_waddr;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic        m_we;
    logic        m_busy;
    logic        sb_empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH), .WA_W(30)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_wd     (d_wd),
        .d_dt     (d_dt),
        .d_rd     (d_rd),
        .d_err    (d_err),
        .d_stall  (d_stall),
        .m_raddr  (m_raddr),
        .m_rd     (m_rd),
        .m_waddr  (m_waddr),
        .m_wd     (m_wd),
        .m_be     (m_be),
        .m_we     (m_we),
        .m_busy   (m_busy),
        .sb_empty (sb_empty)
    );

    // RAM seen by the DUT (written by its m_* port) and the model's own RAM copy
    logic [31:0] dut_ram   [256] = '{default: 32'h0};
    logic [31:0] model_ram [256] = '{default: 32'h0};

    assign m_rd = dut_ram[m_raddr[7:0]];

    always @(posedge clk) begin
        if (m_we) begin
            for (int b = 0; b < 4; b++) begin
                if (m_be[b]) dut_ram[m_waddr[7:0]][8*b +: 8] <= m_wd[8*b +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference load extraction from the access rules
    function automatic logic [31:0] ref_load(input mem_dt_e dt, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] s;
        case (dt)
            DT_BYTE:  begin s = w >> (8 * off);     return {{24{s[7]}}, s[7:0]};   end
            DT_UBYTE: begin s = w >> (8 * off);     return {24'h0, s[7:0]};        end
            DT_HALF:  begin s = w >> (16 * off[1]); return {{16{s[15]}}, s[15:0]}; end
            DT_UHALF: begin s = w >> (16 * off[1]); return {16'h0, s[15:0]};       end
            default:  return w;
        endcase
    endfunction

    // Behavioural model: ordered queue of pending stores
    typedef struct {
        logic [29:0] wa;
        logic [3:0]  be;
        logic [31:0] data;
    } ment_t;

    ment_t       mq[$];
    ment_t       ne;
    logic        mis, e_mwe, e_stall;
    logic [31:0] w, e_rd;
    logic        stall_m = 1'b0;

    // Per-cycle compare against the model, then advance the model by one edge
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_m_we", 32'(m_we), 32'd0);
            chk("rst_m_be", 32'(m_be), 32'd0);
            chk("rst_sb_empty", 32'(sb_empty), 32'd1);
            chk("rst_d_stall", 32'(d_stall), 32'd0);
            chk("rst_d_err", 32'(d_err), 32'(ENOERR));
            mq.delete();
            stall_m = 1'b0;
        end else begin
            mis = ((d_dt == DT_HALF || d_dt == DT_UHALF) && d_addr[0]) ||
                  (d_dt == DT_WORD && d_addr[1:0] != 2'b00);
            e_mwe   = (mq.size() != 0) && !m_busy;
            e_stall = d_we && !mis && (mq.size() == DEPTH) && !e_mwe;
            stall_m = e_stall;
            chk("m_we", 32'(m_we), 32'(e_mwe));
            chk("sb_empty", 32'(sb_empty), 32'(mq.size() == 0));
            chk("d_stall", 32'(d_stall), 32'(e_stall));
            chk("d_err", 32'(d_err), mis ? 32'(EALIGN) : 32'(ENOERR));
            if (e_mwe) begin
                chk("m_waddr", 32'(m_waddr), 32'(mq[0].wa));
                chk("m_be", 32'(m_be), 32'(mq[0].be));
                chk("m_wd", m_wd, mq[0].data);
            end
            if (!d_we) begin
                w = model_ram[d_addr[9:2]];
                foreach (mq[i]) begin
                    if (mq[i].wa == d_addr[31:2]) begin
                        for (int b = 0; b < 4; b++)
                            if (mq[i].be[b]) w[8*b +: 8] = mq[i].data[8*b +: 8];
                    end
                end
                e_rd = mis ? 32'h0 : ref_load(d_dt, d_addr[1:0], w);
                chk("d_rd", d_rd, e_rd);
            end
            if (e_mwe) begin
                for (int b = 0; b < 4; b++)
                    if (mq[0].be[b]) model_ram[mq[0].wa[7:0]][8*b +: 8] = mq[0].data[8*b +: 8];
                void'(mq.pop_front());
            end
            if (d_we && !mis && !e_stall) begin
                ne.wa = d_addr[31:2];
                case (d_dt)
                    DT_BYTE, DT_UBYTE: begin ne.be = 4'b0001 << d_addr[1:0]; ne.data = {4{d_wd[7:0]}};  end
                    DT_HALF, DT_UHALF: begin ne.be = 4'b0011 << d_addr[1:0]; ne.data = {2{d_wd[15:0]}}; end
                    default:           begin ne.be = 4'b1111;                ne.data = d_wd;            end
                endcase
                mq.push_back(ne);
            end
        end
    end

    // One CPU cycle: drive after the edge, return at the following negedge
    task automatic drive(input logic we, input mem_dt_e dt, input logic [31:0] a,
                         input logic [31:0] wd, input logic busy);
        @(posedge clk);
        #1;
        d_we   = we;
        d_dt   = dt;
        d_addr = a;
        d_wd   = wd;
        m_busy = busy;
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            drive(1'b0, DT_WORD, 32'h2000, 32'h0, 1'b0);
            if (sb_empty) done = 1'b1;
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    mem_dt_e dts [5] = '{DT_BYTE, DT_HALF, DT_WORD, DT_UBYTE, DT_UHALF};

    initial begin
        rst    = 1'b1;
        d_we   = 1'b0;
        d_dt   = DT_WORD;
        d_addr = 32'h2000;
        d_wd   = 32'h0;
        m_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_sb_empty", 32'(sb_empty), 32'd1);
        chk("reset_m_we", 32'(m_we), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Forwarding of a store held back by a busy RAM, then its single drain write
        drive(1'b1, DT_WORD, 32'h2000, 32'd32, 1'b1);
        chk("t1_no_stall", 32'(d_stall), 32'd0);
        drive(1'b0, DT_WORD, 32'h2000, 32'h0, 1'b1);
        chk("t1_fwd_lw", d_rd, 32'd32);
        drive(1'b0, DT_WORD, 32'h2000, 32'h0, 1'b0);
        chk("t1_m_we", 32'(m_we), 32'd1);
        chk("t1_m_waddr", 32'(m_waddr), 32'h800);
        chk("t1_m_be", 32'(m_be), 32'hf);
        chk("t1_m_wd", m_wd, 32'd32);
        drive(1'b0, DT_WORD, 32'h2000, 32'h0, 1'b0);
        chk("t1_m_we_once", 32'(m_we), 32'd0);
        chk("t1_empty", 32'(sb_empty), 32'd1);
        chk("t1_ram_lw", d_rd, 32'd32);

        // Byte store merged over a word store, with signed/unsigned byte loads
        drive(1'b1, DT_WORD, 32'h2004, 32'hdeadbeef, 1'b1);
        drive(1'b1, DT_BYTE, 32'h2005, 32'h11, 1'b1);
        drive(1'b0, DT_WORD, 32'h2004, 32'h0, 1'b1);
        chk("t2_lw_merge", d_rd, 32'hdead11ef);
        drive(1'b0, DT_UBYTE, 32'h2005, 32'h0, 1'b1);
        chk("t2_lbu", d_rd, 32'h11);
        drive(1'b0, DT_BYTE, 32'h2007, 32'h0, 1'b1);
        chk("t2_lb", d_rd, 32'hffffffde);
        drain("t2_drain");

        // Fill to DEPTH, stall on the next store, release with a same-cycle pop
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, DT_WORD, 32'h2010 + 32'(4 * i), 32'h100 + 32'(i), 1'b1);
        drive(1'b1, DT_WORD, 32'h2020, 32'h104, 1'b1);
        chk("t3_stall", 32'(d_stall), 32'd1);
        drive(1'b1, DT_WORD, 32'h2020, 32'h104, 1'b0);
        chk("t3_stall_drop", 32'(d_stall), 32'd0);
        chk("t3_pop_waddr", 32'(m_waddr), 32'h804);
        drain("t3_drain");
        chk("t3_ram_last", dut_ram[8], 32'h104);
        chk("t3_ram_first", dut_ram[4], 32'h100);

        // Misaligned store and load
        drive(1'b1, DT_HALF, 32'h2001, 32'h1234, 1'b0);
        chk("t4_st_err", 32'(d_err), 32'(EALIGN));
        drive(1'b0, DT_WORD, 32'h2002, 32'h0, 1'b0);
        chk("t4_no_enq", 32'(sb_empty), 32'd1);
        chk("t4_ld_err", 32'(d_err), 32'(EALIGN));
        chk("t4_ld_zero", d_rd, 32'h0);

        // Reset in the middle of a drain drops the remaining entries at once
        drive(1'b1, DT_WORD, 32'h2000, 32'ha, 1'b1);
        drive(1'b1, DT_WORD, 32'h2004, 32'hb, 1'b1);
        drive(1'b1, DT_WORD, 32'h2008, 32'hc, 1'b1);
        drive(1'b0, DT_WORD, 32'h2000, 32'h0, 1'b0);
        chk("t5_draining", 32'(m_we), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_m_we", 32'(m_we), 32'd0);
        chk("t5_rst_empty", 32'(sb_empty), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, DT_WORD, 32'h2000, 32'h0, 1'b0);
        chk("t5_raw_2000", d_rd, 32'ha);
        drive(1'b0, DT_WORD, 32'h2008, 32'h0, 1'b0);
        chk("t5_raw_2008", d_rd, 32'h0);

        // Back-to-back sw / lw / sw with a free RAM port
        drive(1'b1, DT_WORD, 32'h2030, 32'd32, 1'b0);
        chk("t6_sw1_stall", 32'(d_stall), 32'd0);
        drive(1'b0, DT_WORD, 32'h2030, 32'h0, 1'b0);
        chk("t6_lw_fwd", d_rd, 32'd32);
        chk("t6_pop_same", 32'(m_we), 32'd1);
        drive(1'b1, DT_WORD, 32'h2034, 32'd32, 1'b0);
        chk("t6_sw2_stall", 32'(d_stall), 32'd0);
        drain("t6_drain");
        chk("t6_ram0", dut_ram[12], 32'd32);
        chk("t6_ram1", dut_ram[13], 32'd32);

        // Randomized traffic; a stalled store is held until accepted
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (!stall_m) begin
                rst    = ($urandom_range(0, 199) == 0);
                d_we   = 1'($urandom_range(0, 1));
                d_dt   = dts[$urandom_range(0, 4)];
                d_addr = 32'h2000 + 32'($urandom_range(0, 31));
                d_wd   = $urandom;
            end else begin
                rst = 1'b0;
            end
            m_busy = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        drain("rand_drain");
        for (int i = 0; i < 16; i++) chk("ram_final", dut_ram[i], model_ram[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
